// File: rtl/rijndael_keyexpand_ctrl_if.sv
// Key-load and round-key stream bundle between the key loader, the key-expansion
// sequencer and the round-key consumer.
interface rijndael_keyexpand_ctrl_if #(
  parameter int unsigned NK = 4
);
  localparam int unsigned KEYSIZE = 32 * NK;
  localparam int unsigned RK_W    = 128;
  localparam int unsigned IDX_W   = 4;

  logic               start_i;
  logic [KEYSIZE-1:0] key_i;
  logic               busy_o;
  logic               rk_valid_o;
  logic               rk_ready_i;
  logic [RK_W-1:0]    rk_o;
  logic [IDX_W-1:0]   rk_idx_o;
  logic               done_o;

  modport master (
    output start_i, key_i, rk_ready_i,
    input  busy_o, rk_valid_o, rk_o, rk_idx_o, done_o
  );

  modport slave (
    input  start_i, key_i, rk_ready_i,
    output busy_o, rk_valid_o, rk_o, rk_idx_o, done_o
  );
endinterface

// File: rtl/rijndael_keyexpand_ctrl.sv
// Iterative AES-128/AES-256 key expansion: one schedule step per cycle, round keys
// streamed over valid/ready with registered outputs.
module rijndael_keyschedulestep #(
  parameter int unsigned NK = 4
) (
  input  logic [32*NK-1:0] keystate_i,
  input  logic [7:0]       rcon_i,
  output logic [32*NK-1:0] next_keystate_o
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254 by square-and-multiply) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0] w  [NK];
  logic [31:0] nw [NK];

  // One full NK-word step; for NK=8 the fifth word takes SubWord without rotation or rcon
  always_comb begin
    for (int i = 0; i < NK; i++) w[i] = keystate_i[32*i +: 32];
    nw[0] = w[0] ^ sub_word({w[NK-1][23:0], w[NK-1][31:24]}) ^ {rcon_i, 24'h000000};
    for (int i = 1; i < NK; i++) begin
      if (NK == 8 && i == 4) nw[i] = w[i] ^ sub_word(nw[i-1]);
      else                   nw[i] = w[i] ^ nw[i-1];
    end
    for (int i = 0; i < NK; i++) next_keystate_o[32*i +: 32] = nw[i];
  end
endmodule

module rijndael_keyexpand_ctrl #(
  parameter int unsigned NK = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  rijndael_keyexpand_ctrl_if.slave bus
);
  localparam int unsigned KEYSIZE = 32 * NK;
  localparam int unsigned NR      = NK + 6;
  localparam int unsigned RK_W    = 128;
  localparam int unsigned IDX_W   = 4;

  if (NK != 4 && NK != 8) begin : g_bad_nk
    $error("rijndael_keyexpand_ctrl: NK must be 4 or 8");
  end

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_e             state_q, state_d;
  logic [KEYSIZE-1:0] ks_q, ks_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               half_q, half_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RK_W-1:0]    rk_q, rk_d;
  logic               done_c;
  logic [KEYSIZE-1:0] step_ks;
  logic [RK_W-1:0]    ks_hi;

  rijndael_keyschedulestep #(.NK(NK)) u_step (
    .keystate_i      (ks_q),
    .rcon_i          (rcon_q),
    .next_keystate_o (step_ks)
  );

  // Upper 128 bits of the key state only exist for AES-256
  if (NK == 8) begin : g_hi
    assign ks_hi = ks_q[KEYSIZE-1 -: RK_W];
  end else begin : g_no_hi
    assign ks_hi = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ks_q    <= '0;
      rcon_q  <= 8'h01;
      half_q  <= 1'b0;
      idx_q   <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      ks_q    <= ks_d;
      rcon_q  <= rcon_d;
      half_q  <= half_d;
      idx_q   <= idx_d;
      rk_q    <= rk_d;
    end
  end

  // rk_d is prepared one cycle ahead so rk_o never depends on rk_ready_i
  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    rcon_d  = rcon_q;
    half_d  = half_q;
    idx_d   = idx_q;
    rk_d    = rk_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          ks_d    = bus.key_i;
          rcon_d  = 8'h01;
          half_d  = 1'b0;
          idx_d   = '0;
          rk_d    = bus.key_i[RK_W-1:0];
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.rk_ready_i) begin
          if (idx_q == IDX_W'(NR)) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (NK == 4 || half_q) begin
              ks_d   = step_ks;
              rcon_d = xtime(rcon_q);
              half_d = 1'b0;
              rk_d   = step_ks[RK_W-1:0];
            end else begin
              half_d = 1'b1;
              rk_d   = ks_hi;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o     = (state_q == EMIT);
  assign bus.rk_valid_o = (state_q == EMIT);
  assign bus.rk_o       = rk_q;
  assign bus.rk_idx_o   = idx_q;
  assign bus.done_o     = done_c;
endmodule

// File: tb/tb_rijndael_keyexpand_ctrl.sv
// Randomized bench for rijndael_keyexpand_ctrl (NK=4 and NK=8 instances) against a
// word-level FIPS-197 key-expansion model.
module tb_rijndael_keyexpand_ctrl;
  localparam logic [127:0] K128 = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] K256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                   32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         start [2];
  logic         ready [2];
  logic [255:0] key   [2];
  logic         valid [2];
  logic         busy  [2];
  logic         done  [2];
  logic [127:0] rk    [2];
  logic [3:0]   idx   [2];

  rijndael_keyexpand_ctrl_if #(.NK(4)) bus4 ();
  rijndael_keyexpand_ctrl_if #(.NK(8)) bus8 ();

  rijndael_keyexpand_ctrl #(.NK(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4));
  rijndael_keyexpand_ctrl #(.NK(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

  assign bus4.start_i    = start[0];
  assign bus4.key_i      = key[0][127:0];
  assign bus4.rk_ready_i = ready[0];
  assign valid[0] = bus4.rk_valid_o;
  assign busy[0]  = bus4.busy_o;
  assign done[0]  = bus4.done_o;
  assign rk[0]    = bus4.rk_o;
  assign idx[0]   = bus4.rk_idx_o;

  assign bus8.start_i    = start[1];
  assign bus8.key_i      = key[1];
  assign bus8.rk_ready_i = ready[1];
  assign valid[1] = bus8.rk_valid_o;
  assign busy[1]  = bus8.busy_o;
  assign done[1]  = bus8.done_o;
  assign rk[1]    = bus8.rk_o;
  assign idx[1]   = bus8.rk_idx_o;

  int total;
  int bad;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   rcon_t  [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_tab [2][15];
  logic [127:0] seen    [2][15];
  bit           active  [2];
  int           ptr     [2];
  int           cnt     [2];

  task automatic chk(input string name, input int d, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[nk%0d] got=%h exp=%h", name, (d == 0) ? 4 : 8, got, exp);
    end
  endtask

  function automatic int nr_of(input int d);
    return (d == 0) ? 10 : 14;
  endfunction

  // S-box from the generator-3 walk over GF(2^8)
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Textbook word-by-word expansion into the expected round-key table
  function automatic void expand(input int d, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nr;
    nk = (d == 0) ? 4 : 8;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h000000};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_tab[d][r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Cycle-by-cycle check of both instances against the expected stream
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("valid", d, 128'(valid[d]), 128'(active[d]));
        chk("busy", d, 128'(busy[d]), 128'(active[d]));
        if (valid[d]) cnt[d]++;
        if (active[d] && valid[d]) begin
          chk("rk", d, rk[d], exp_tab[d][ptr[d]]);
          chk("idx", d, 128'(idx[d]), 128'(ptr[d]));
          if (ready[d]) begin
            chk("done", d, 128'(done[d]), 128'(ptr[d] == nr_of(d)));
            seen[d][ptr[d]] = rk[d];
            ptr[d]++;
            if (ptr[d] > nr_of(d)) active[d] = 1'b0;
          end else begin
            chk("done_stall", d, 128'(done[d]), 128'(0));
          end
        end else begin
          chk("done_idle", d, 128'(done[d]), 128'(0));
        end
      end
    end
  end

  // Called at posedge+1 with the instance idle; returns at posedge+1 after acceptance
  task automatic start_run(input int d, input logic [255:0] k);
    start[d] = 1'b1;
    key[d]   = k;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    key[d]   = rand_key();
    expand(d, k);
    ptr[d]    = 0;
    cnt[d]    = 0;
    active[d] = 1'b1;
  endtask

  task automatic wait_done(input int d, input bit stall, input bit poke);
    int n;
    n = 0;
    while (active[d] && n < 400) begin
      ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && (ptr[d] == 3 || (ptr[d] == nr_of(d) && ready[d]))) begin
        start[d] = 1'b1;
        key[d]   = rand_key();
      end else begin
        start[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start[d] = 1'b0;
    ready[d] = 1'b1;
    if (active[d]) begin
      total++;
      bad++;
      $display("FAIL timeout[nk%0d] got=ptr%0d exp=idle", (d == 0) ? 4 : 8, ptr[d]);
      active[d] = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] k;
    int n;
    total = 0;
    bad   = 0;
    build_sbox();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; ready[d] = 1'b1; key[d] = '0;
      active[d] = 1'b0; ptr[d] = 0; cnt[d] = 0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, 128'(valid[d]), 128'(0));
      chk("rst_busy", d, 128'(busy[d]), 128'(0));
      chk("rst_done", d, 128'(done[d]), 128'(0));
      chk("rst_idx", d, 128'(idx[d]), 128'(0));
      chk("rst_rk", d, rk[d], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_run(0, {128'h0, K128});
    wait_done(0, 1'b0, 1'b0);
    chk("cnt128", 0, 128'(cnt[0]), 128'(11));
    chk("fips128_idx1", 0, seen[0][1], 128'h2a6c7605_23a33939_88542cb1_a0fafe17);
    chk("fips128_idx10", 0, seen[0][10], 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8);

    start_run(1, K256);
    wait_done(1, 1'b0, 1'b0);
    chk("cnt256", 1, 128'(cnt[1]), 128'(15));
    chk("fips256_idx2", 1, seen[1][2], 128'h2067fcde_a51a8b5f_8e6925af_9ba35411);
    chk("fips256_idx3w0", 1, 128'(seen[1][3][31:0]), 128'(32'ha8b09c1a));
    chk("fips256_idx14", 1, seen[1][14], 128'he6188d0b_046df344_706c631e_fe4890d1 ^
                                         128'he6188d0b_046df344_706c631e_fe4890d1 ^
                                         128'h706c631e_046df344_e6188d0b_fe4890d1);

    // Stalled, back-to-back runs with ignored starts at idx 3 and in the done cycle
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        k = (i == 0) ? ((d == 0) ? {128'h0, K128} : K256) : rand_key();
        start_run(d, k);
        wait_done(d, 1'b1, i < 2);
      end
    end

    // Asynchronous reset in the middle of an AES-128 run
    start_run(0, rand_key());
    n = 0;
    while (ptr[0] != 5 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_idx_reached", 0, 128'(ptr[0]), 128'(5));
    rst_n     = 1'b0;
    active[0] = 1'b0;
    #1;
    chk("mid_rst_valid", 0, 128'(valid[0]), 128'(0));
    chk("mid_rst_busy", 0, 128'(busy[0]), 128'(0));
    chk("mid_rst_idx", 0, 128'(idx[0]), 128'(0));
    chk("mid_rst_rk", 0, rk[0], 128'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    k = rand_key();
    start_run(0, k);
    wait_done(0, 1'b0, 1'b0);
    chk("restart_idx0", 0, seen[0][0], k[127:0]);
    chk("restart_cnt", 0, 128'(cnt[0]), 128'(11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
